// File: rtl/sha512_pkg.sv
// Shared SHA-512 constants, FSM state type and round/schedule helper functions.
package sha512_pkg;

    typedef enum logic [1:0] {StIdle, StRound, StDone} t_sha512_state;

    localparam logic [63:0] K [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    // Packed so that IV[0] is the first SHA-512 word.
    localparam logic [7:0][63:0] IV = {
        64'h5be0cd19137e2179, 64'h1f83d9abfb41bd6b, 64'h9b05688c2b3e6c1f, 64'h510e527fade682d1,
        64'ha54ff53a5f1d36f1, 64'h3c6ef372fe94f82b, 64'hbb67ae8584caa73b, 64'h6a09e667f3bcc908
    };

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] bswap64(input logic [63:0] x);
        logic [63:0] y;
        for (int b = 0; b < 8; b++) y[8*b +: 8] = x[8*(7-b) +: 8];
        return y;
    endfunction

    function automatic logic [63:0] big_sigma0(input logic [63:0] a);
        return rotr64(a, 28) ^ rotr64(a, 34) ^ rotr64(a, 39);
    endfunction

    function automatic logic [63:0] big_sigma1(input logic [63:0] e);
        return rotr64(e, 14) ^ rotr64(e, 18) ^ rotr64(e, 41);
    endfunction

    function automatic logic [63:0] small_sigma0(input logic [63:0] x);
        return rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
    endfunction

    function automatic logic [63:0] small_sigma1(input logic [63:0] x);
        return rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
    endfunction

    function automatic logic [63:0] ch(input logic [63:0] e, input logic [63:0] f,
                                       input logic [63:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [63:0] maj(input logic [63:0] a, input logic [63:0] b,
                                        input logic [63:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // Byte-swapped so host memory holds the canonical big-endian digest.
    function automatic logic [511:0] pack_digest(input logic [7:0][63:0] h);
        logic [511:0] d;
        for (int i = 0; i < 8; i++) d[64*i +: 64] = bswap64(h[i]);
        return d;
    endfunction

endpackage

// File: rtl/sha512_schedule.sv
// SHA-512 message schedule: 16-word shift register producing W[t] for the current round.
module sha512_schedule
    import sha512_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [15:0][63:0] init_words,
    output logic [63:0]       w_t
);

    logic [15:0][63:0] w_q, w_d;
    logic [63:0]       w_new;

    // While round t runs, w_q[j] holds W[t+j].
    assign w_new = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
    assign w_t   = w_q[0];

    always_comb begin
        w_d = w_q;
        if (load) begin
            w_d = init_words;
        end else if (advance) begin
            w_d = {w_new, w_q[15:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_q <= '0;
        end else begin
            w_q <= w_d;
        end
    end

endmodule

// File: rtl/sha512_core.sv
// Iterative SHA-512 compression engine: one round per cycle, hash state chained across blocks.
module sha512_core
    import sha512_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic [1:0][511:0] block,
    input  logic             block_valid,
    output logic             ready,
    output logic [511:0]     digest,
    output logic             digest_valid
);

    t_sha512_state     state_q, state_d;
    logic [6:0]        rnd_q, rnd_d;
    logic [7:0][63:0]  work_q, work_d;
    logic [7:0][63:0]  hash_q, hash_d;
    logic [511:0]      digest_q, digest_d;
    logic              digest_valid_q, digest_valid_d;
    logic [1023:0]     block_flat;
    logic [15:0][63:0] init_words;
    logic              sched_load, sched_advance;
    logic [63:0]       w_t, t1, t2;

    assign ready        = (state_q == StIdle);
    assign digest       = digest_q;
    assign digest_valid = digest_valid_q;
    assign block_flat   = block;

    always_comb begin
        for (int i = 0; i < 16; i++) init_words[i] = bswap64(block_flat[64*i +: 64]);
    end

    sha512_schedule u_schedule (
        .clk        (clk),
        .reset      (reset),
        .load       (sched_load),
        .advance    (sched_advance),
        .init_words (init_words),
        .w_t        (w_t)
    );

    // work_q[0..7] = a..h
    assign t1 = work_q[7] + big_sigma1(work_q[4]) + ch(work_q[4], work_q[5], work_q[6])
              + K[rnd_q] + w_t;
    assign t2 = big_sigma0(work_q[0]) + maj(work_q[0], work_q[1], work_q[2]);

    always_comb begin
        state_d        = state_q;
        rnd_d          = rnd_q;
        work_d         = work_q;
        hash_d         = hash_q;
        digest_d       = digest_q;
        digest_valid_d = 1'b0;
        sched_load     = 1'b0;
        sched_advance  = 1'b0;

        // restart outranks everything, including a coincident block_valid
        if (restart) begin
            state_d  = StIdle;
            rnd_d    = '0;
            hash_d   = IV;
            digest_d = pack_digest(IV);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (block_valid) begin
                        state_d    = StRound;
                        work_d     = hash_q;
                        rnd_d      = '0;
                        sched_load = 1'b1;
                    end
                end
                StRound: begin
                    sched_advance = 1'b1;
                    work_d = {work_q[6], work_q[5], work_q[4], work_q[3] + t1,
                              work_q[2], work_q[1], work_q[0], t1 + t2};
                    if (rnd_q == 7'd79) begin
                        state_d = StDone;
                        rnd_d   = '0;
                    end else begin
                        rnd_d = rnd_q + 7'd1;
                    end
                end
                StDone: begin
                    for (int i = 0; i < 8; i++) hash_d[i] = hash_q[i] + work_q[i];
                    digest_d       = pack_digest(hash_d);
                    digest_valid_d = 1'b1;
                    state_d        = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            rnd_q          <= '0;
            work_q         <= '0;
            hash_q         <= IV;
            digest_q       <= pack_digest(IV);
            digest_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rnd_q          <= rnd_d;
            work_q         <= work_d;
            hash_q         <= hash_d;
            digest_q       <= digest_d;
            digest_valid_q <= digest_valid_d;
        end
    end

endmodule

// File: tb/tb_sha512_core.sv
// Self-checking bench for sha512_core: cycle model plus digest scoreboard and known-answer vectors.
module tb_sha512_core;
    import sha512_pkg::*;

    typedef logic [7:0][63:0] hash_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             restart;
    logic [1:0][511:0] block;
    logic             block_valid;
    logic             ready;
    logic [511:0]     digest;
    logic             digest_valid;

    int            n_total = 0;
    int            n_bad = 0;
    int            n_pulses = 0;
    hash_t         mdl_h;
    int            mdl_busy;
    logic          mdl_pulse;
    logic [511:0]  mdl_digest, mdl_pending;
    logic [511:0]  exp_q [$];
    logic [1023:0] msg_blks [$];
    logic [511:0]  abc_kat, fips2_kat, d1, d2;

    always #5 clk = ~clk;

    sha512_core dut (
        .clk          (clk),
        .reset        (reset),
        .restart      (restart),
        .block        (block),
        .block_valid  (block_valid),
        .ready        (ready),
        .digest       (digest),
        .digest_valid (digest_valid)
    );

    function automatic logic [63:0] tb_rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] tb_bswap64(input logic [63:0] x);
        logic [63:0] y;
        for (int b = 0; b < 8; b++) y[8*b +: 8] = x[8*(7-b) +: 8];
        return y;
    endfunction

    function automatic logic [511:0] tb_pack(input hash_t h);
        logic [511:0] d;
        for (int i = 0; i < 8; i++) d[64*i +: 64] = tb_bswap64(h[i]);
        return d;
    endfunction

    // Straight FIPS 180-4 compression with a full 80-word schedule.
    function automatic hash_t mdl_compress(input hash_t h, input logic [1023:0] blk);
        logic [63:0] w [80];
        logic [63:0] v [8];
        logic [63:0] t1, t2;
        hash_t r;
        for (int t = 0; t < 16; t++) w[t] = tb_bswap64(blk[64*t +: 64]);
        for (int t = 16; t < 80; t++)
            w[t] = (tb_rotr(w[t-2], 19) ^ tb_rotr(w[t-2], 61) ^ (w[t-2] >> 6)) + w[t-7]
                 + (tb_rotr(w[t-15], 1) ^ tb_rotr(w[t-15], 8) ^ (w[t-15] >> 7)) + w[t-16];
        for (int i = 0; i < 8; i++) v[i] = h[i];
        for (int t = 0; t < 80; t++) begin
            t1 = v[7] + (tb_rotr(v[4], 14) ^ tb_rotr(v[4], 18) ^ tb_rotr(v[4], 41))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
            t2 = (tb_rotr(v[0], 28) ^ tb_rotr(v[0], 34) ^ tb_rotr(v[0], 39))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[i] = h[i] + v[i];
        return r;
    endfunction

    function automatic logic [1023:0] rand_blk();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic load_msg(input string s);
        int          n, total, p;
        longint      bits;
        logic [7:0]  v;
        logic [1023:0] blk;
        n     = s.len();
        bits  = longint'(n) * 8;
        total = ((n + 17 + 127) / 128) * 128;
        msg_blks.delete();
        for (int b = 0; b < total / 128; b++) begin
            blk = '0;
            for (int j = 0; j < 128; j++) begin
                p = b * 128 + j;
                if (p < n) v = s[p];
                else if (p == n) v = 8'h80;
                else if (p >= total - 8) v = 8'(bits >> (8 * (total - 1 - p)));
                else v = 8'h00;
                blk[8*j +: 8] = v;
            end
            msg_blks.push_back(blk);
        end
    endtask

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic mdl_reset();
        mdl_h      = IV;
        mdl_busy   = 0;
        mdl_pulse  = 1'b0;
        mdl_digest = tb_pack(IV);
        exp_q.delete();
    endtask

    // Mirrors what the DUT samples at this posedge; inputs are stable here.
    task automatic mdl_step();
        mdl_pulse = 1'b0;
        if (reset) begin
            mdl_reset();
        end else if (restart) begin
            mdl_h      = IV;
            mdl_busy   = 0;
            mdl_digest = tb_pack(IV);
            exp_q.delete();
        end else if (mdl_busy > 0) begin
            mdl_busy--;
            if (mdl_busy == 0) begin
                mdl_pulse  = 1'b1;
                mdl_digest = mdl_pending;
            end
        end else if (block_valid) begin
            mdl_h       = mdl_compress(mdl_h, block);
            mdl_pending = tb_pack(mdl_h);
            exp_q.push_back(mdl_pending);
            mdl_busy    = 81;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        mdl_step();
        #1;
        check_eq("ready", 512'(ready), 512'(mdl_busy == 0));
        check_eq("digest_valid", 512'(digest_valid), 512'(mdl_pulse));
        if (digest_valid) begin
            n_pulses++;
            check_eq("sb_has_entry", 512'(exp_q.size() != 0), 512'(1'b1));
            if (exp_q.size() != 0) check_eq("sb_digest", digest, exp_q.pop_front());
        end
        check_eq("digest_hold", digest, mdl_digest);
    endtask

    task automatic send_block(input logic [1023:0] blk, output logic [511:0] dout);
        int guard;
        guard       = 0;
        block       = blk;
        block_valid = 1'b1;
        tick();
        block_valid = 1'b0;
        while (digest_valid !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        check_eq("latency", 512'(guard), 512'(81));
        dout = digest;
    endtask

    task automatic send_abc(input string tag);
        logic [511:0] d;
        load_msg("abc");
        send_block(msg_blks[0], d);
        check_eq(tag, d, abc_kat);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        hash_t kh;
        kh = {64'h2a9ac94fa54ca49f, 64'h454d4423643ce80e, 64'h36ba3c23a3feebbd,
              64'h2192992a274fc1a8, 64'h0a9eeee64b55d39a, 64'h12e6fa4e89a97ea2,
              64'hcc417349ae204131, 64'hddaf35a193617aba};
        abc_kat = tb_pack(kh);
        kh = {64'h5e96e55b874be909, 64'hc7d329eeb6dd2654, 64'h331b99dec4b5433a,
              64'h501d289e4900f7e4, 64'h7299aeadb6889018, 64'h8f7779c6eb9f7fa1,
              64'h8cf4f72814fc143f, 64'h8e959b75dae313da};
        fips2_kat = tb_pack(kh);

        reset = 1'b0; restart = 1'b0; block_valid = 1'b0; block = '0;
        mdl_reset();
        #1 reset = 1'b1;
        #2;
        check_eq("rst_ready", 512'(ready), 512'(1'b1));
        check_eq("rst_dvalid", 512'(digest_valid), 512'(1'b0));
        check_eq("rst_digest", digest, tb_pack(IV));
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // 1: "abc" after reset
        send_abc("t1_abc_kat");
        tick();

        // 2: two-block FIPS message, back-to-back
        restart = 1'b1; tick(); restart = 1'b0;
        load_msg({"abcdefghbcdefghicdefghijdefghijkefghijklfghijklmghijklmn",
                  "hijklmnoijklmnopjklmnopqklmnopqrlmnopqrsmnopqrstnopqrstu"});
        check_eq("t2_nblocks", 512'(msg_blks.size()), 512'(2));
        send_block(msg_blks[0], d1);
        send_block(msg_blks[1], d2);
        check_eq("t2_fips_kat", d2, fips2_kat);

        // 3: block_valid held high with changing data
        tick();
        n_pulses    = 0;
        block_valid = 1'b1;
        for (int c = 0; c < 164; c++) begin
            block = rand_blk();
            tick();
        end
        block_valid = 1'b0;
        check_eq("t3_pulses", 512'(n_pulses), 512'(2));

        // 4: asynchronous reset around round 40
        load_msg("abc");
        block = msg_blks[0]; block_valid = 1'b1; tick(); block_valid = 1'b0;
        repeat (41) tick();
        reset = 1'b1;
        #2;
        mdl_reset();
        check_eq("t4_async_ready", 512'(ready), 512'(1'b1));
        check_eq("t4_async_dvalid", 512'(digest_valid), 512'(1'b0));
        check_eq("t4_async_digest", digest, tb_pack(IV));
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        send_abc("t4_abc_kat");

        // 5: restart mid-block, then restart coincident with block_valid
        load_msg("abc");
        block = msg_blks[0]; block_valid = 1'b1; tick(); block_valid = 1'b0;
        repeat (30) tick();
        restart = 1'b1; tick(); restart = 1'b0;
        n_pulses = 0;
        repeat (90) tick();
        check_eq("t5_no_abort_pulse", 512'(n_pulses), 512'(0));
        send_abc("t5_abc_kat");
        restart = 1'b1; block_valid = 1'b1; tick();
        restart = 1'b0; block_valid = 1'b0;
        check_eq("t5_drop_ready", 512'(ready), 512'(1'b1));
        repeat (3) tick();

        // 6: chaining without restart, then with restart in between
        send_abc("t6_first_kat");
        load_msg("abc");
        send_block(msg_blks[0], d2);
        check_eq("t6_chain_differs", 512'(d2 != abc_kat), 512'(1'b1));
        restart = 1'b1; tick(); restart = 1'b0;
        send_abc("t6_restart_kat_a");
        restart = 1'b1; tick(); restart = 1'b0;
        send_abc("t6_restart_kat_b");
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
